// File: rtl/fix_div.sv
// rtl/fix_div.sv - sequential unsigned restoring divider with valid/ready handshakes
//
// Divides a 2*INPUT_WIDTH-bit dividend by an INPUT_WIDTH-bit divisor. The block
// produces one quotient bit per clock.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   dividend, divisor    : operands, sampled on the accept edge only
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   quotient, remainder  : floor(dividend/divisor), dividend mod divisor
//   overflow             : quotient does not fit INPUT_WIDTH bits, or divisor == 0
module fix_div #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OUTPUT_WIDTH-1:0] dividend,
    input  logic [INPUT_WIDTH-1:0]  divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INPUT_WIDTH-1:0]  quotient,
    output logic [INPUT_WIDTH-1:0]  remainder,
    output logic                    overflow
);
    localparam int W  = INPUT_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    r_q;        // partial remainder; always < D, so W bits suffice
    logic [W-1:0]    q_q;        // dividend low half shifting out, quotient bits shifting in
    logic [W-1:0]    d_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_pend_q; // overflow detected at accept, reported on the next edge
    logic            out_valid_q;
    logic [W-1:0]    quotient_q;
    logic [W-1:0]    remainder_q;
    logic            overflow_q;

    logic [W-1:0]    h_in;
    logic [W:0]      r_shift;
    logic [W:0]      r_sub;
    logic            qbit;
    logic [W-1:0]    r_d;
    logic [W-1:0]    q_d;

    assign h_in = dividend[OUTPUT_WIDTH-1:W];

    // One restoring step. R' < 2*D, so R' - D has its MSB clear exactly when
    // R' >= D: the top bit of the (W+1)-bit difference acts as the borrow.
    always_comb begin
        r_shift = {r_q, q_q[W-1]};
        r_sub   = r_shift - {1'b0, d_q};
        qbit    = ~r_sub[W];
        r_d     = qbit ? r_sub[W-1:0] : r_shift[W-1:0];
        q_d     = {q_q[W-2:0], qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= CALC;
                        cnt_q   <= '0;
                        d_q     <= divisor;
                        if (h_in >= divisor) begin
                            // Covers divisor == 0 as well; spend one CALC cycle
                            // so the overflow result appears one edge later.
                            ovf_pend_q <= 1'b1;
                        end else begin
                            ovf_pend_q <= 1'b0;
                            r_q        <= h_in;
                            q_q        <= dividend[W-1:0];
                        end
                    end
                end
                CALC: begin
                    if (ovf_pend_q) begin
                        ovf_pend_q  <= 1'b0;
                        quotient_q  <= '1;
                        remainder_q <= '0;
                        overflow_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        r_q   <= r_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(W - 1)) begin
                            quotient_q  <= q_d;
                            remainder_q <= r_d;
                            overflow_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign overflow  = overflow_q;
endmodule

// File: doc/fix_div.md
# fix_div

Sequential unsigned fixed-point divider. It is the inverse of the `fix_mult` combinational multiplier: it takes a 2·INPUT_WIDTH-bit dividend, such as a `fix_mult` product, and a divisor of INPUT_WIDTH bits. It returns an INPUT_WIDTH-bit quotient and remainder using restoring division, one quotient bit per clock. Operands enter and results leave through valid/ready handshakes, so the block sits between pipeline stages of the datapath.

## Interface
- `INPUT_WIDTH`, 16: width of divisor, quotient and remainder; must be ≥ 2.
- `OUTPUT_WIDTH`, 2*INPUT_WIDTH: width of the dividend; fixed at 2*INPUT_WIDTH.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  dividend/divisor valid.
- `in_ready`  out  1  block can accept operands.
- `dividend`  in  OUTPUT_WIDTH  unsigned dividend.
- `divisor`  in  INPUT_WIDTH  unsigned divisor.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `quotient`  out  INPUT_WIDTH  floor(dividend / divisor).
- `remainder`  out  INPUT_WIDTH  dividend mod divisor.
- `overflow`  out  1  quotient not representable, or divisor == 0.

## Operation
- The FSM has three states: IDLE, CALC and DONE. `in_ready` = (state == IDLE), combinational from state. `out_valid` = (state == DONE), registered.
- **IDLE:**
  - On `in_valid && in_ready`, capture the operands.
  - Let H = `dividend[OUTPUT_WIDTH-1:INPUT_WIDTH]` and L = `dividend[INPUT_WIDTH-1:0]`.
  - If H ≥ `divisor` (this includes `divisor` == 0): go to DONE with `quotient` = all ones, `remainder` = 0, `overflow` = 1.
  - Otherwise: load partial remainder R (INPUT_WIDTH+1 bits) = {0,H}, shift register Q = L, D = `divisor`, step counter = 0. Go to CALC with `overflow` = 0.
- **CALC, per edge:**
  - R' = {R[INPUT_WIDTH-1:0], Q[INPUT_WIDTH-1]}.
  - If R' ≥ {0,D}: R = R' − D and qbit = 1. Otherwise: R = R' and qbit = 0.
  - Q = {Q[INPUT_WIDTH-2:0], qbit}; counter increments.
  - On the edge performing step INPUT_WIDTH−1: register `quotient` = final Q and `remainder` = final R[INPUT_WIDTH-1:0], then go to DONE.
- **DONE:**
  - Outputs are held stable.
  - On `out_ready`, go to IDLE.
  - New operands are not accepted in DONE (`in_ready` = 0).
- **Width rules:** the precondition H < D guarantees the quotient fits INPUT_WIDTH bits and R < D after every step. The comparison and subtraction are INPUT_WIDTH+1 bits wide. No signed handling.
- Operand inputs are sampled only at the accept edge; changes afterwards have no effect.
- `quotient`, `remainder` and `overflow` keep their last values after leaving DONE until the next result is registered.

## Timing
- **Reset values** (immediate on `rst` assertion, independent of `clk`): state = IDLE, `out_valid` = 0, `quotient` = 0, `remainder` = 0, `overflow` = 0, internal R/Q/D/counter = 0. Consequently `in_ready` = 1 during and after reset.
- **Reset mid-operation:** the operation in flight is discarded and produces no `out_valid`. The first accept after reset release behaves normally.
- **Normal latency:** with the accept on edge 0, `out_valid` rises after edge INPUT_WIDTH (16 cycles at the default width).
- **Overflow latency:** `out_valid` rises after edge 1.
- **Output handshake:** the result transfers on the first edge where `out_valid && out_ready`. `in_ready` rises in the following cycle. `out_ready` asserted early has no effect before DONE.
- **Throughput:** the block holds one operation at a time. Minimum accept-to-accept spacing is INPUT_WIDTH+2 cycles (normal) and 3 cycles (overflow), when `out_ready` is held at 1.
- `in_valid` while `in_ready` = 0 is ignored; the upstream must hold its operands until it sees `in_ready`.

## Test plan
- **Basic division:** `dividend` = 0x0000_0064, `divisor` = 7, `out_ready` = 1 → `quotient` = 14, `remainder` = 2, `overflow` = 0. `out_valid` rises exactly 16 cycles after the accept edge and lasts one cycle.
- **Maximum operands:** `dividend` = 0xFFFE_0001, `divisor` = 0xFFFF → `quotient` = 0xFFFF, `remainder` = 0.
- **Round trip with `fix_mult`:** for 1000 random a and b≠0, dividing `fix_mult(a,b)` by b → `quotient` = a, `remainder` = 0.
- **Overflow:** `divisor` = 0 → `overflow` = 1, `quotient` = 0xFFFF, `remainder` = 0, `out_valid` 1 cycle after accept. Separately, `dividend` = 0x0001_0000 with `divisor` = 1 gives the same result (H = D case).
- **Backpressure:** hold `out_ready` = 0 for 5 cycles in DONE while pulsing `in_valid` with new operands → `quotient`, `remainder` and `overflow` stay stable, `in_ready` stays 0, and the new operands are not captured. `out_ready` = 1 → one transfer, then `in_ready` = 1 on the next cycle.
- **Reset mid-operation:** assert `rst` asynchronously 8 cycles into CALC → `out_valid` = 0 and outputs are 0 immediately, with no result emitted for the aborted operation. After release, 1000 / 10 → `quotient` = 100, `remainder` = 0 with 16-cycle latency.
